lcd_msg_arbiter: RTL and testbench

- Shares the LCD1602 character display between NUM_REQ sensor requesters, for example temperature and humidity formatters.
- After power-up, runs the HD44780 init command sequence once. It then grants requesters in round-robin order.
- For each grant, streams one 16-character row update: an address command followed by 16 data bytes.
- Drives a byte-level valid/ready command port into the LCD bus-timing driver, which generates lcd_en, lcd_rs and lcd_data.

---
 rtl/lcd_msg_arbiter_if.sv | 30 +++
 rtl/lcd_msg_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_lcd_msg_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_msg_arbiter_if.sv
// Purpose : requester and LCD command-port bundle for lcd_msg_arbiter.
// Signals : req/req_row/req_text  - per-requester row update requests (in to arbiter)
//           ack                   - per-requester completion pulse (out of arbiter)
//           cmd_valid/cmd_rs/cmd_data/cmd_ready - byte handshake to the LCD driver
//           init_done/busy        - status (out of arbiter)
// Modports: master = arbiter side, slave = requesters + LCD driver side.
interface lcd_msg_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_row;
    logic [NUM_REQ*128-1:0] req_text;
    logic [NUM_REQ-1:0]     ack;
    logic                   cmd_valid;
    logic                   cmd_rs;
    logic [7:0]             cmd_data;
    logic                   cmd_ready;
    logic                   init_done;
    logic                   busy;

    modport master (
        input  req, req_row, req_text, cmd_ready,
        output ack, cmd_valid, cmd_rs, cmd_data, init_done, busy
    );

    modport slave (
        output req, req_row, req_text, cmd_ready,
        input  ack, cmd_valid, cmd_rs, cmd_data, init_done, busy
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Purpose : shares an LCD1602 between NUM_REQ requesters. Runs the HD44780 init
//           sequence once after a power-up delay, then grants requesters in
//           round-robin order; each grant streams an address byte plus 16 chars.
// Ports   : clk, rst_n (async active-low)
//           io_bus : lcd_msg_arbiter_if.master (requests, acks, LCD byte port, status)
module lcd_msg_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned POWERUP_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_msg_arbiter_if.master    io_bus
);
    localparam int unsigned TEXT_W   = 128;
    localparam int unsigned CNT_W    = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned INIT_LEN = 5;

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_IDLE, S_ADDR, S_CHAR, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_init_idx, w_init_idx_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [TEXT_W-1:0]  r_buf, w_buf_nxt;
    logic               r_row, w_row_nxt;

    logic               r_cmd_valid, w_cmd_valid;
    logic               r_cmd_rs, w_cmd_rs;
    logic [7:0]         r_cmd_data, w_cmd_data;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic               r_init_done, w_init_done;
    logic               r_busy, w_busy;

    logic               w_xfer;
    logic               w_grant;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W+6:0]   w_text_base;
    logic [IDX_W-1:0]   w_byte_sel;
    int                 v_cand;

    assign w_xfer = r_cmd_valid & io_bus.cmd_ready;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h08;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h0C;
        endcase
    endfunction

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_POWERUP;
            r_cnt       <= '0;
            r_init_idx  <= '0;
            r_idx       <= '0;
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_buf       <= '0;
            r_row       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_rs    <= 1'b0;
            r_cmd_data  <= '0;
            r_ack       <= '0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_idx  <= w_init_idx_nxt;
            r_idx       <= w_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_buf       <= w_buf_nxt;
            r_row       <= w_row_nxt;
            r_cmd_valid <= w_cmd_valid;
            r_cmd_rs    <= w_cmd_rs;
            r_cmd_data  <= w_cmd_data;
            r_ack       <= w_ack;
            r_init_done <= w_init_done;
            r_busy      <= w_busy;
        end
    end

    // Next-state and datapath updates; round-robin search starts at pointer+1.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_init_idx_nxt = r_init_idx;
        w_idx_nxt      = r_idx;
        w_ptr_nxt      = r_ptr;
        w_buf_nxt      = r_buf;
        w_row_nxt      = r_row;
        w_grant        = |io_bus.req;
        w_winner       = r_ptr;
        v_cand         = 0;

        // Descending scan so the closest candidate after the pointer wins.
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            v_cand = int'(r_ptr) + k;
            if (v_cand >= int'(NUM_REQ)) v_cand = v_cand - int'(NUM_REQ);
            if (io_bus.req[PTR_W'(v_cand)]) w_winner = PTR_W'(v_cand);
        end
        w_text_base = {w_winner, 7'd0};

        case (r_state)
            S_POWERUP: begin
                if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_INIT: begin
                if (w_xfer) begin
                    if (r_init_idx == 3'(INIT_LEN - 1)) begin
                        w_state_nxt    = S_IDLE;
                        w_init_idx_nxt = '0;
                    end else begin
                        w_init_idx_nxt = r_init_idx + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ADDR;
                    w_ptr_nxt   = w_winner;
                    w_buf_nxt   = io_bus.req_text[w_text_base +: TEXT_W];
                    w_row_nxt   = io_bus.req_row[w_winner];
                end
            end
            S_ADDR: begin
                if (w_xfer) begin
                    w_state_nxt = S_CHAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CHAR: begin
                if (w_xfer) begin
                    if (r_idx == IDX_W'(15)) w_state_nxt = S_DONE;
                    else                     w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_POWERUP;
        endcase
    end

    // Output decode from next state so outputs are registered yet aligned with state.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_rs    = 1'b0;
        w_cmd_data  = '0;
        w_ack       = '0;
        w_byte_sel  = IDX_W'(15) - w_idx_nxt;
        w_busy      = (w_state_nxt != S_IDLE);
        w_init_done = (w_state_nxt != S_POWERUP) && (w_state_nxt != S_INIT);

        case (w_state_nxt)
            S_INIT: begin
                w_cmd_valid = 1'b1;
                w_cmd_data  = init_byte(w_init_idx_nxt);
            end
            S_ADDR: begin
                w_cmd_valid = 1'b1;
                w_cmd_data  = w_row_nxt ? 8'hC0 : 8'h80;
            end
            S_CHAR: begin
                w_cmd_valid = 1'b1;
                w_cmd_rs    = 1'b1;
                w_cmd_data  = w_buf_nxt[{w_byte_sel, 3'b000} +: 8];
            end
            S_DONE:  w_ack = NUM_REQ'(1) << w_ptr_nxt;
            default: ;
        endcase
    end

    assign io_bus.cmd_valid = r_cmd_valid;
    assign io_bus.cmd_rs    = r_cmd_rs;
    assign io_bus.cmd_data  = r_cmd_data;
    assign io_bus.ack       = r_ack;
    assign io_bus.init_done = r_init_done;
    assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Purpose : scoreboard bench for lcd_msg_arbiter. A round-robin reference model
//           turns each request round into expected LCD bytes and ack pulses; a
//           monitor pops and compares whenever the DUT transfers a byte or acks.
module tb_lcd_msg_arbiter;
    localparam int NUM_REQ = 2;
    localparam int PWR     = 10;
    localparam int MAXB    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_msg_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    lcd_msg_arbiter #(.NUM_REQ(NUM_REQ), .POWERUP_CYCLES(PWR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;

    logic [8:0]         exp_bytes[$];
    logic [NUM_REQ-1:0] exp_acks[$];
    int                 order[$];
    int                 m_ptr;

    logic [127:0] r_text[NUM_REQ][MAXB];
    logic         r_row[NUM_REQ][MAXB];
    int           r_n[NUM_REQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic logic [127:0] rand_text();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        logic [7:0] seq[5];
        seq = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        exp_bytes.delete();
        exp_acks.delete();
        m_ptr = NUM_REQ - 1;
        foreach (seq[i]) exp_bytes.push_back({1'b0, seq[i]});
    endtask

    // Reference: grant order from the round-robin rule, then each grant's 17 bytes and ack.
    task automatic plan_round();
        int rem[NUM_REQ];
        int bk[NUM_REQ];
        int left;
        int w;
        logic [NUM_REQ-1:0] a;
        left = 0;
        order.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = r_n[i];
            bk[i]  = 0;
            left  += r_n[i];
        end
        while (left > 0) begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (w < 0 && rem[c] > 0) w = c;
            end
            exp_bytes.push_back({1'b0, r_row[w][bk[w]] ? 8'hC0 : 8'h80});
            for (int c = 0; c < 16; c++)
                exp_bytes.push_back({1'b1, r_text[w][bk[w]][(15-c)*8 +: 8]});
            a = '0;
            a[w] = 1'b1;
            exp_acks.push_back(a);
            order.push_back(w);
            rem[w]--;
            bk[w]++;
            left--;
            m_ptr = w;
        end
    endtask

    task automatic load_round();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req[i]               = (r_n[i] > 0);
            bus.req_row[i]           = r_row[i][0];
            bus.req_text[i*128 +: 128] = r_text[i][0];
        end
    endtask

    // Keeps each req held until its bursts are acked; scrambles the winner's text right after grant.
    task automatic drive_round(input int budget, input bit stop_idx7, output bit hit);
        int rem[NUM_REQ];
        int bk[NUM_REQ];
        int g, acks, total, bb, w;
        logic pv;
        g = 0; acks = 0; total = 0; bb = 0; pv = 1'b0; hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = r_n[i];
            bk[i]  = 0;
            total += r_n[i];
        end
        for (int cyc = 0; cyc < budget && acks < total && !hit; cyc++) begin
            @(negedge clk);
            if (bus.cmd_valid && !pv && !bus.cmd_rs && bus.init_done) begin
                if (g < order.size()) begin
                    w = order[g];
                    bus.req_text[w*128 +: 128] = rand_text();
                    bus.req_row[w]             = 1'($urandom);
                end
                g++;
                bb = 0;
            end
            if (stop_idx7 && bus.init_done && bb == 8 && bus.cmd_valid && bus.cmd_rs) begin
                hit = 1'b1;
            end else begin
                if (bus.cmd_valid && bus.cmd_ready) bb++;
                pv = bus.cmd_valid;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus.ack[i]) begin
                        acks++;
                        rem[i]--;
                        bk[i]++;
                        if (rem[i] <= 0) begin
                            bus.req[i] = 1'b0;
                        end else if (bk[i] < MAXB) begin
                            bus.req_text[i*128 +: 128] = r_text[i][bk[i]];
                            bus.req_row[i]             = r_row[i][bk[i]];
                        end
                    end
                end
            end
        end
        if (!stop_idx7 && acks < total) fail_now("round_timeout");
        if (stop_idx7 && !hit) fail_now("idx7_not_reached");
    endtask

    task automatic release_and_check_powerup();
        int cyc;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.cmd_valid) break;
        end
        chk("first_valid_cycle", 32'(cyc), 32'(PWR));
    endtask

    // cmd_ready driver: always high, or random low stretches of 0-7 cycles.
    initial begin
        int low;
        low = 0;
        bus.cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (low > 0) begin
                bus.cmd_ready = 1'b0;
                low--;
            end else if (ready_mode != 0 && $urandom_range(0, 2) == 0) begin
                low = $urandom_range(0, 7);
                if (low > 0) begin
                    bus.cmd_ready = 1'b0;
                    low--;
                end else begin
                    bus.cmd_ready = 1'b1;
                end
            end else begin
                bus.cmd_ready = 1'b1;
            end
        end
    end

    // Monitor: compares transfers, acks, held-byte stability and init_done against the model.
    initial begin
        logic pv, pr;
        logic [8:0] pbyte;
        int xfers;
        pv = 1'b0; pr = 1'b0; pbyte = '0; xfers = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xfers = 0;
                pv    = 1'b0;
                continue;
            end
            chk("init_done", 32'(bus.init_done), 32'(xfers >= 5));
            if (pv && !pr)
                chk("hold_stable", {22'd0, bus.cmd_valid, bus.cmd_rs, bus.cmd_data}, {22'd0, 1'b1, pbyte});
            if (bus.cmd_valid) chk("busy_while_valid", 32'(bus.busy), 32'd1);
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                else chk("byte", {23'd0, bus.cmd_rs, bus.cmd_data}, {23'd0, exp_bytes.pop_front()});
                xfers++;
            end
            if (bus.ack != '0) begin
                if (exp_acks.size() == 0) fail_now("unexpected_ack");
                else chk("ack", 32'(bus.ack), 32'(exp_acks.pop_front()));
            end
            pv    = bus.cmd_valid;
            pr    = bus.cmd_ready;
            pbyte = {bus.cmd_rs, bus.cmd_data};
        end
    end

    initial begin
        bit hit;
        bus.req      = '0;
        bus.req_row  = '0;
        bus.req_text = '0;
        rst_n        = 1'b0;
        model_reset();

        // Round 1: request held through power-up and init.
        r_n[0] = 1; r_n[1] = 0;
        r_text[0][0] = "Temperature:    ";
        r_row[0][0]  = 1'b1;
        plan_round();
        load_round();
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_data", {23'd0, bus.cmd_rs, bus.cmd_data}, 32'd0);
        release_and_check_powerup();
        drive_round(2000, 1'b0, hit);

        // Round 2: both requesters held, two bursts each, fixed rows.
        r_n[0] = 2; r_n[1] = 2;
        r_text[0][0] = "Temp: 23.5 C    "; r_text[0][1] = rand_text();
        r_text[1][0] = "Hum:  61 %RH    "; r_text[1][1] = rand_text();
        r_row[0][0] = 1'b0; r_row[0][1] = 1'b0;
        r_row[1][0] = 1'b1; r_row[1][1] = 1'b1;
        plan_round();
        load_round();
        drive_round(2000, 1'b0, hit);

        // Round 3: random back-pressure and random request mixes.
        ready_mode = 1;
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_n[i] = $urandom_range(0, 3);
                for (int b = 0; b < MAXB; b++) begin
                    r_text[i][b] = rand_text();
                    r_row[i][b]  = 1'($urandom);
                end
            end
            if (r_n[0] + r_n[1] == 0) r_n[0] = 1;
            plan_round();
            load_round();
            drive_round(6000, 1'b0, hit);
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);

        // Round 4: reset while char index 7 is on the port.
        r_n[0] = 1; r_n[1] = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_text[i][0] = rand_text();
            r_row[i][0]  = 1'($urandom);
        end
        plan_round();
        load_round();
        drive_round(2000, 1'b1, hit);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("midrst_init_done", 32'(bus.init_done), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        model_reset();

        // Round 5: requests held across reset; full power-up and init must come first.
        r_n[0] = 1; r_n[1] = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_text[i][0] = rand_text();
            r_row[i][0]  = 1'($urandom);
        end
        plan_round();
        load_round();
        repeat (3) @(negedge clk);
        release_and_check_powerup();
        drive_round(2000, 1'b0, hit);

        repeat (5) @(negedge clk);
        chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
        chk("acks_left", 32'(exp_acks.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
